// File: rtl/pipelined_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_shifter
//  Description : Barrel shifter/rotator (SLL/SRL/SRA/ROR) with one register
//                stage per power-of-two shift step and valid/ready flow
//                control. Carries an opaque tag alongside each operation.
//  Options     : SHIFTER_ZERO_FLAG_EN - adds out_zero (registered result==0)
//  Ports       : clk, rst            clock / synchronous active-high reset
//                in_valid/in_ready   input handshake
//                in_data/in_cnt      operand / shift amount (0..WIDTH-1)
//                in_mode             00 SLL, 01 SRL, 10 SRA, 11 ROR
//                in_tag              opaque tag, returned unchanged
//                out_valid/out_ready output handshake
//                out_data/out_tag    result / its tag
//                out_zero            result==0 (option only)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_shifter #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       in_valid,
    output logic                            in_ready,
    input  wire logic [WIDTH-1:0]           in_data,
    input  wire logic [$clog2(WIDTH)-1:0]   in_cnt,
    input  wire logic [1:0]                 in_mode,
    input  wire logic [TAG_W-1:0]           in_tag,
    output logic                            out_valid,
    input  wire logic                       out_ready,
    output logic [WIDTH-1:0]                out_data,
`ifdef SHIFTER_ZERO_FLAG_EN
    output logic                            out_zero,
`endif
    output logic [TAG_W-1:0]                out_tag
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] c_MODE_SLL = 2'b00;
    localparam logic [1:0] c_MODE_SRL = 2'b01;
    localparam logic [1:0] c_MODE_SRA = 2'b10;
    localparam logic [1:0] c_MODE_ROR = 2'b11;

    // Stage registers
    logic [CNT_W-1:0]   r_valid;
    logic [WIDTH-1:0]   r_data [CNT_W];
    logic [CNT_W-1:0]   r_cnt  [CNT_W];
    logic [1:0]         r_mode [CNT_W];
    logic [TAG_W-1:0]   r_tag  [CNT_W];
    logic               r_sign [CNT_W];

    // Per-stage upstream view and next data
    logic [CNT_W-1:0]   w_ready;
    logic               w_src_valid [CNT_W];
    logic [WIDTH-1:0]   w_src_data  [CNT_W];
    logic [CNT_W-1:0]   w_src_cnt   [CNT_W];
    logic [1:0]         w_src_mode  [CNT_W];
    logic [TAG_W-1:0]   w_src_tag   [CNT_W];
    logic               w_src_sign  [CNT_W];
    logic [WIDTH-1:0]   w_nxt_data  [CNT_W];

    // One conditional shift step of fixed distance s. SRA fills from the
    // sign captured at input, so a stage never re-reads the shifted MSB.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input logic             en,
        input logic [1:0]       mode,
        input logic             sign,
        input int               s
    );
        logic [WIDTH-1:0] res;
        res = d;
        if (en) begin
            case (mode)
                c_MODE_SLL: res = d << s;
                c_MODE_SRL: res = d >> s;
                c_MODE_SRA: res = (d >> s) | (sign ? ~({WIDTH{1'b1}} >> s) : '0);
                c_MODE_ROR: res = (d >> s) | (d << (WIDTH - s));
                default:    res = d;
            endcase
        end
        return res;
    endfunction

    // Stage k is ready when empty or when everything downstream can move,
    // i.e. out_ready or any bubble at or after k. Accumulated through a
    // local variable to keep the chain free of combinational self-reference.
    always_comb begin : p_ready
        logic v_acc;
        v_acc = out_ready;
        w_ready = '0;
        for (int k = CNT_W - 1; k >= 0; k--) begin
            v_acc      = ~r_valid[k] | v_acc;
            w_ready[k] = v_acc;
        end
    end

    assign in_ready = w_ready[0] & ~rst;

    always_comb begin
        w_src_valid[0] = in_valid & in_ready;
        w_src_data[0]  = in_data;
        w_src_cnt[0]   = in_cnt;
        w_src_mode[0]  = in_mode;
        w_src_tag[0]   = in_tag;
        w_src_sign[0]  = in_data[WIDTH-1];
        for (int k = 1; k < CNT_W; k++) begin
            w_src_valid[k] = r_valid[k-1];
            w_src_data[k]  = r_data[k-1];
            w_src_cnt[k]   = r_cnt[k-1];
            w_src_mode[k]  = r_mode[k-1];
            w_src_tag[k]   = r_tag[k-1];
            w_src_sign[k]  = r_sign[k-1];
        end
        for (int k = 0; k < CNT_W; k++) begin
            w_nxt_data[k] = shift_step(w_src_data[k], w_src_cnt[k][k],
                                       w_src_mode[k], w_src_sign[k], 1 << k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int k = 0; k < CNT_W; k++) begin
                r_data[k] <= '0;
                r_cnt[k]  <= '0;
                r_mode[k] <= '0;
                r_tag[k]  <= '0;
                r_sign[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < CNT_W; k++) begin
                // Stalled stages hold; ready stages take upstream even when
                // it is a bubble, which collapses gaps in the pipe.
                if (w_ready[k]) begin
                    r_valid[k] <= w_src_valid[k];
                    r_data[k]  <= w_nxt_data[k];
                    r_cnt[k]   <= w_src_cnt[k];
                    r_mode[k]  <= w_src_mode[k];
                    r_tag[k]   <= w_src_tag[k];
                    r_sign[k]  <= w_src_sign[k];
                end
            end
        end
    end

    assign out_valid = r_valid[CNT_W-1];
    assign out_data  = r_data[CNT_W-1];
    assign out_tag   = r_tag[CNT_W-1];

`ifdef SHIFTER_ZERO_FLAG_EN
    logic r_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero <= 1'b0;
        end else if (w_ready[CNT_W-1]) begin
            r_zero <= (w_nxt_data[CNT_W-1] == '0);
        end
    end

    assign out_zero = r_zero;
`endif

    // Last-stage control fields are kept for uniformity but have no consumer.
    logic w_unused_last;
    assign w_unused_last = ^{r_cnt[CNT_W-1], r_mode[CNT_W-1], r_sign[CNT_W-1]};

endmodule
`default_nettype wire

// File: tb/tb_pipelined_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_shifter
//  Description : Self-checking bench for pipelined_shifter (WIDTH=16,
//                TAG_W=4). Expected results come from a whole-word
//                arithmetic shift model and a FIFO of accepted ops.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_shifter;

    localparam int W  = 16;
    localparam int TW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic [CW-1:0] in_cnt = '0;
    logic [1:0]    in_mode = '0;
    logic [TW-1:0] in_tag = '0;
    wire           in_ready;
    wire           out_valid;
    wire  [W-1:0]  out_data;
    wire  [TW-1:0] out_tag;
`ifdef SHIFTER_ZERO_FLAG_EN
    wire           out_zero;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0]  exp_d [$];
    logic [TW-1:0] exp_t [$];

    pipelined_shifter #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cnt    (in_cnt),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef SHIFTER_ZERO_FLAG_EN
        .out_zero  (out_zero),
`endif
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    // Whole-word reference: the shift as a single arithmetic operation.
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input int c,
                                           input logic [1:0] m);
        logic [W-1:0] r;
        case (m)
            2'd0: r = d << c;
            2'd1: r = d >> c;
            2'd2: r = $signed(d) >>> c;
            default: r = (d >> c) | (d << (W - c));
        endcase
        return r;
    endfunction

    task automatic set_op(input logic v, input logic [1:0] m, input logic [W-1:0] d,
                          input logic [CW-1:0] c, input logic [TW-1:0] t);
        in_valid = v;
        in_mode  = m;
        in_data  = d;
        in_cnt   = c;
        in_tag   = t;
    endtask

    task automatic set_rand_op(input logic v);
        set_op(v, 2'($urandom_range(0, 3)), W'($urandom), CW'($urandom_range(0, W-1)),
               TW'($urandom));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_op(1'b0, 2'd0, '0, '0, '0);
        out_ready = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        @(negedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_tag !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%h t=%h want 0/0000/0",
                     out_valid, out_data, out_tag);
        end
`ifdef SHIFTER_ZERO_FLAG_EN
        n_checks++;
        if (out_zero !== 1'b0) begin
            n_fail++; $display("FAIL reset_zero: got %b want 0", out_zero);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    // Single ops with hand-computed results; also measures latency.
    task automatic test_directed();
        logic [1:0]  m  [9] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
        logic [15:0] d  [9] = '{16'h8001, 16'h8000, 16'hF000, 16'h0001, 16'h1234,
                                16'h1234, 16'h1234, 16'h1234, 16'h9000};
        logic [3:0]  c  [9] = '{4'd1, 4'd15, 4'd4, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd3};
        logic [15:0] ex [9] = '{16'hC000, 16'hFFFF, 16'h0F00, 16'h8000, 16'h1234,
                                16'h1234, 16'h1234, 16'h1234, 16'hF200};
        for (int i = 0; i < 9; i++) begin
            int lat;
            logic [TW-1:0] tg;
            tg = (i == 0) ? 4'd3 : TW'(i);
            @(negedge clk);
            out_ready = 1'b1;
            set_op(1'b1, m[i], d[i], c[i], tg);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++; $display("FAIL dir_accept[%0d]: in_ready=%b want 1", i, in_ready);
            end
            lat = 0;
            do begin
                @(negedge clk);
                in_valid = 1'b0;
                lat++;
                #1;
            end while (out_valid !== 1'b1 && lat < 20);
            n_checks++;
            if (lat != CW) begin
                n_fail++; $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, CW);
            end
            n_checks++;
            if (out_data !== ex[i] || out_tag !== tg) begin
                n_fail++;
                $display("FAIL dir_result[%0d]: got d=%h t=%h want d=%h t=%h",
                         i, out_data, out_tag, ex[i], tg);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0, first_cyc = 0;
        logic [W-1:0] ed [8];
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            @(negedge clk);
            if (sent < 8) set_rand_op(1'b1); else in_valid = 1'b0;
            if (sent < 8) in_tag = TW'(sent);
            #1;
            if (out_valid && out_ready) begin
                if (got == 0) first_cyc = cyc;
                n_checks++;
                if (out_tag !== TW'(got) || out_data !== ed[got] || cyc != first_cyc + got) begin
                    n_fail++;
                    $display("FAIL b2b[%0d]: got t=%h d=%h cyc=%0d want t=%h d=%h cyc=%0d",
                             got, out_tag, out_data, cyc, TW'(got), ed[got], first_cyc + got);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                ed[sent] = model(in_data, int'(in_cnt), in_mode);
                sent++;
            end
        end
        n_checks++;
        if (got != 8) begin
            n_fail++; $display("FAIL b2b_count: got %0d want 8", got);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int sent = 0, got = 0;
        logic [W-1:0] held = '0;
        logic seen = 1'b0;
        exp_d.delete(); exp_t.delete();
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (sent < 6) begin set_rand_op(1'b1); in_tag = TW'(sent + 8); end
            else in_valid = 1'b0;
            #1;
            if (out_valid) begin
                if (seen) begin
                    n_checks++;
                    if (out_data !== held) begin
                        n_fail++; $display("FAIL bp_stable: got %h want %h", out_data, held);
                    end
                end
                held = out_data;
                seen = 1'b1;
            end
            if (in_valid && in_ready) begin
                exp_d.push_back(model(in_data, int'(in_cnt), in_mode));
                exp_t.push_back(in_tag);
                sent++;
            end
        end
        n_checks++;
        if (sent != 4 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_full: accepted %0d in_ready=%b want 4 and 0", sent, in_ready);
        end
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (sent < 6) begin set_rand_op(1'b1); in_tag = TW'(sent + 8); end
            else in_valid = 1'b0;
            #1;
            if (out_valid) begin
                n_checks++;
                if (exp_d.size() == 0) begin
                    n_fail++; $display("FAIL bp_extra: got d=%h want no output", out_data);
                end else begin
                    logic [W-1:0] e_d;
                    logic [TW-1:0] e_t;
                    e_d = exp_d.pop_front();
                    e_t = exp_t.pop_front();
                    if (out_data !== e_d || out_tag !== e_t) begin
                        n_fail++;
                        $display("FAIL bp_drain[%0d]: got d=%h t=%h want d=%h t=%h",
                                 got, out_data, out_tag, e_d, e_t);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_d.push_back(model(in_data, int'(in_cnt), in_mode));
                exp_t.push_back(in_tag);
                sent++;
            end
        end
        n_checks++;
        if (got != 6) begin
            n_fail++; $display("FAIL bp_count: got %0d want 6", got);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midstream();
        int stale = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_rand_op(1'b1);
            #1;
        end
        @(negedge clk);
        rst = 1'b1;
        set_rand_op(1'b1);  // offered during reset: must be ignored
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_in_ready: got %b want 0", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_rst_after: out_valid=%b in_ready=%b want 0 and 1",
                               out_valid, in_ready);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (out_valid) stale++;
        end
        n_checks++;
        if (stale != 0) begin
            n_fail++; $display("FAIL mid_rst_stale: got %0d outputs want 0", stale);
        end
    endtask

`ifdef SHIFTER_ZERO_FLAG_EN
    task automatic test_zero_flag();
        logic [15:0] d [2] = '{16'h8000, 16'h0001};
        logic [1:0]  m [2] = '{2'd0, 2'd3};
        logic        z [2] = '{1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            int n;
            @(negedge clk);
            set_op(1'b1, m[i], d[i], 4'd1, 4'd5);
            n = 0;
            do begin
                @(negedge clk);
                in_valid = 1'b0;
                n++;
                #1;
            end while (out_valid !== 1'b1 && n < 20);
            n_checks++;
            if (out_zero !== z[i] || out_data !== model(d[i], 1, m[i])) begin
                n_fail++; $display("FAIL zero_flag[%0d]: got z=%b d=%h want z=%b", i,
                                   out_zero, out_data, z[i]);
            end
        end
    endtask
`endif

    task automatic test_random();
        int got = 0;
        exp_d.delete(); exp_t.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if (cyc < 560) set_rand_op(($urandom % 4) != 0); else in_valid = 1'b0;
            out_ready = (cyc >= 560) || (($urandom % 4) != 0);
            #1;
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_d.size() == 0) begin
                    n_fail++; $display("FAIL rnd_extra: got d=%h want no output", out_data);
                end else begin
                    logic [W-1:0] e_d;
                    logic [TW-1:0] e_t;
                    e_d = exp_d.pop_front();
                    e_t = exp_t.pop_front();
                    if (out_data !== e_d || out_tag !== e_t) begin
                        n_fail++;
                        $display("FAIL rnd[%0d]: got d=%h t=%h want d=%h t=%h",
                                 got, out_data, out_tag, e_d, e_t);
                    end
`ifdef SHIFTER_ZERO_FLAG_EN
                    if (out_zero !== (e_d == '0)) begin
                        n_fail++; $display("FAIL rnd_zero[%0d]: got %b want %b",
                                           got, out_zero, (e_d == '0));
                    end
`endif
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_d.push_back(model(in_data, int'(in_cnt), in_mode));
                exp_t.push_back(in_tag);
            end
        end
        n_checks++;
        if (exp_d.size() != 0) begin
            n_fail++; $display("FAIL rnd_lost: %0d ops never emerged want 0", exp_d.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
`ifdef SHIFTER_ZERO_FLAG_EN
        test_zero_flag();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
